// File: rtl/jump_return_control.sv
// Jump/return redirect control with a circular return-address stack.
// J/JAL/JR produce a registered redirect; JAL pushes pc_plus4 and JR pops and predicts.
module jump_return_control #(
    parameter int          DATA_W = 32,
    parameter int          DEPTH  = 8,
    parameter logic [2:0]  OP_J   = 3'b010,
    parameter logic [2:0]  OP_JAL = 3'b011
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [2:0]                opcode,
    input  logic [5:0]                func,
    input  logic [DATA_W-1:0]         ReadData1,
    input  logic [DATA_W-1:0]         pc_plus4,
    input  logic [DATA_W-1:0]         jump_target,
    output logic                      redirect,
    output logic [DATA_W-1:0]         target,
    output logic                      ras_hit,
    output logic                      ras_miss,
    output logic [$clog2(DEPTH):0]    ras_count,
    output logic                      ras_overflow
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [8:0]        JR_CODE  = 9'b000001000;

    logic [DATA_W-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_redirect;
    logic [DATA_W-1:0] r_target;
    logic              r_hit;
    logic              r_miss;

    logic              w_accept;
    logic              w_isJr;
    logic              w_isJ;
    logic              w_isJal;
    logic              w_isJump;
    logic              w_empty;
    logic              w_full;
    logic [PTR_W-1:0]  w_topIdx;
    logic [DATA_W-1:0] w_topData;
    logic              w_topMatch;
    logic              w_push;
    logic              w_pop;

    // r_ptr names the next free slot, so the top of stack sits one below it.
    assign w_accept   = instr_valid && !stall && !flush && !reset;
    assign w_isJr     = ({opcode, func} == JR_CODE);
    assign w_isJ      = !w_isJr && (opcode == OP_J);
    assign w_isJal    = !w_isJr && !w_isJ && (opcode == OP_JAL);
    assign w_isJump   = w_isJr || w_isJ || w_isJal;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_topIdx   = r_ptr - PTR_W'(1);
    assign w_topData  = r_stack[w_topIdx];
    assign w_topMatch = (w_topData == ReadData1);
    assign w_push     = w_accept && w_isJal;
    assign w_pop      = w_accept && w_isJr && !w_empty;

    // Stack contents carry no reset; a full push lands on the oldest slot.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_stack[r_ptr] <= pc_plus4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_redirect <= 1'b0;
            r_target   <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
        end else if (flush) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_redirect <= 1'b0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
        end else begin
            r_redirect <= w_accept && w_isJump;
            r_hit      <= w_accept && w_isJr && !w_empty && w_topMatch;
            r_miss     <= w_accept && w_isJr && (w_empty || !w_topMatch);
            if (w_accept && w_isJump) begin
                r_target <= w_isJr ? ReadData1 : jump_target;
            end
            if (w_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr   <= r_ptr - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign redirect     = r_redirect;
    assign target       = r_target;
    assign ras_hit      = r_hit;
    assign ras_miss     = r_miss;
    assign ras_count    = r_count;
    assign ras_overflow = r_overflow;

endmodule
